mandelbrot_iter_core: RTL and testbench

- Parametrised per-pixel Mandelbrot iteration engine; successor to the fixed-width fractal datapath inside tt_um_fractal.
- Takes one complex point c, iterates z <- z^2 + c one step per clock, and reports the escape count plus a 6-bit RRGGBB colour chosen by one of four colour modes.
- Sits between the pixel scan/coordinate generator (upstream) and the VGA pixel sink (downstream) on valid/ready handshakes.

---
 rtl/mandelbrot_iter_core_if.sv | 28 ++
 rtl/mandelbrot_iter_core.sv | 170 +++++++++++++++++
 tb/tb_mandelbrot_iter_core.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_iter_core_if.sv
// mandelbrot_iter_core_if: point-request / result handshake bundle between the coordinate generator, the iteration core and the pixel sink
interface mandelbrot_iter_core_if #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  c_re;
    logic signed [WIDTH-1:0]  c_im;
    logic [ITER_W-1:0]        max_iter;
    logic [1:0]               colour_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [ITER_W-1:0]        iter_count;
    logic                     escaped;
    logic [5:0]               colour;
    logic                     busy;

    modport master (
        output in_valid, c_re, c_im, max_iter, colour_mode, out_ready,
        input  in_ready, out_valid, iter_count, escaped, colour, busy
    );

    modport slave (
        input  in_valid, c_re, c_im, max_iter, colour_mode, out_ready,
        output in_ready, out_valid, iter_count, escaped, colour, busy
    );
endinterface

// File: rtl/mandelbrot_iter_core.sv
// mandelbrot_iter_core: one z <- z^2 + c step per clock, escape count and RRGGBB colour; MANDEL_PERIOD_EN adds early exit on detected cycles
module mandelbrot_iter_core #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 12,
    parameter int ITER_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    mandelbrot_iter_core_if.slave   bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int W1 = W2 + 1;
    localparam int SW = W2 + 2;
    localparam logic signed [W1-1:0] FOUR = {{(W1-2*FRAC-3){1'b0}}, 1'b1, {(2*FRAC+2){1'b0}}};
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic [ITER_W-1:0]       n_q, n_d, max_q, max_d, cnt_q, cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic                    esc_q, esc_d;
    logic [5:0]              col_q, col_d;
    logic signed [W2-1:0]    zr2, zi2, zrzi;
    logic signed [W1-1:0]    mag;
    logic signed [SW-1:0]    re_sum, im_sum;
    logic signed [WIDTH-1:0] zr_nx, zi_nx;
    logic [ITER_W-1:0]       n_nx;
    logic                    in_rdy;
`ifdef MANDEL_PERIOD_EN
    logic signed [WIDTH-1:0] snap_re_q, snap_re_d, snap_im_q, snap_im_d;
    logic                    snap_v_q, snap_v_d;
`endif

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        return v > MAXV ? MAXV[WIDTH-1:0] : v < MINV ? MINV[WIDTH-1:0] : v[WIDTH-1:0];
    endfunction

    function automatic logic [5:0] col_map(input logic [5:0] it, input logic [1:0] m);
        return m == 2'd0 ? {3{it[1:0]}} :
               m == 2'd1 ? {it[1:0], it[3:2], it[5:4]} :
               m == 2'd2 ? 6'b111111 :
               (it[0] ? 6'b110000 : 6'b000011);
    endfunction

    assign in_rdy         = (state_q == IDLE) && en;
    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = state_q == DONE;
    assign bus.busy       = state_q == ITER;
    assign bus.iter_count = cnt_q;
    assign bus.escaped    = esc_q;
    assign bus.colour     = col_q;

    // Next state: accept in IDLE, one escape/limit/step evaluation per enabled ITER cycle, drain in DONE
    always_comb begin
        state_d = state_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        n_d     = n_q;
        max_d   = max_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        esc_d   = esc_q;
        col_d   = col_q;
`ifdef MANDEL_PERIOD_EN
        snap_re_d = snap_re_q;
        snap_im_d = snap_im_q;
        snap_v_d  = snap_v_q;
`endif
        zr2    = W2'(zr_q) * W2'(zr_q);
        zi2    = W2'(zi_q) * W2'(zi_q);
        zrzi   = W2'(zr_q) * W2'(zi_q);
        mag    = W1'(zr2) + W1'(zi2);
        re_sum = ((SW'(zr2) - SW'(zi2)) >>> FRAC) + SW'(cr_q);
        im_sum = ((SW'(zrzi) <<< 1) >>> FRAC) + SW'(ci_q);
        zr_nx  = sat(re_sum);
        zi_nx  = sat(im_sum);
        n_nx   = n_q + ITER_W'(1);
        case (state_q)
            IDLE: if (bus.in_valid && in_rdy) begin
                cr_d    = bus.c_re;
                ci_d    = bus.c_im;
                max_d   = bus.max_iter;
                mode_d  = bus.colour_mode;
                zr_d    = '0;
                zi_d    = '0;
                n_d     = '0;
                state_d = ITER;
`ifdef MANDEL_PERIOD_EN
                snap_v_d = 1'b0;
`endif
            end
            ITER: if (en) begin
                if (mag > FOUR) begin
                    state_d = DONE;
                    esc_d   = 1'b1;
                    cnt_d   = n_q;
                    col_d   = col_map(n_q[5:0], mode_q);
                end else if (n_q == max_q) begin
                    state_d = DONE;
                    esc_d   = 1'b0;
                    cnt_d   = max_q;
                    col_d   = '0;
                end else begin
                    zr_d = zr_nx;
                    zi_d = zi_nx;
                    n_d  = n_nx;
`ifdef MANDEL_PERIOD_EN
                    if (snap_v_q && zr_nx == snap_re_q && zi_nx == snap_im_q) begin
                        state_d = DONE;
                        esc_d   = 1'b0;
                        cnt_d   = max_q;
                        col_d   = '0;
                    end else if ((n_nx & (n_nx - ITER_W'(1))) == '0) begin
                        snap_re_d = zr_nx;
                        snap_im_d = zi_nx;
                        snap_v_d  = 1'b1;
                    end
`endif
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight point and clears all results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            zr_q    <= '0;
            zi_q    <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            n_q     <= '0;
            max_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            esc_q   <= 1'b0;
            col_q   <= '0;
`ifdef MANDEL_PERIOD_EN
            snap_re_q <= '0;
            snap_im_q <= '0;
            snap_v_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            n_q     <= n_d;
            max_q   <= max_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            esc_q   <= esc_d;
            col_q   <= col_d;
`ifdef MANDEL_PERIOD_EN
            snap_re_q <= snap_re_d;
            snap_im_q <= snap_im_d;
            snap_v_q  <= snap_v_d;
`endif
        end
    end
endmodule

// File: tb/tb_mandelbrot_iter_core.sv
// tb_mandelbrot_iter_core: directed and random points checked against a plain-arithmetic Mandelbrot reference
module tb_mandelbrot_iter_core;
    localparam int WIDTH  = 16;
    localparam int FRAC   = 12;
    localparam int ITER_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    mandelbrot_iter_core_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus();

    mandelbrot_iter_core #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        longint hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
    endfunction

    // Reference: iterate the complex recurrence with wide integers; cyc counts evaluation cycles
    function automatic void model(input longint cr, input longint ci, input int mx, input int mode,
                                  output int cnt, output bit esc, output int col, output int cyc);
        longint zr = 0, zi = 0, nr, ni, sr = 0, si = 0;
        bit     sv = 0;
        bit     stop = 0;
        cyc = 0;
        cnt = 0;
        esc = 0;
        for (int n = 0; !stop; n++) begin
            cyc++;
            if (zr * zr + zi * zi > (longint'(4) <<< (2 * FRAC))) begin
                esc = 1; cnt = n; stop = 1;
            end else if (n == mx) begin
                esc = 0; cnt = mx; stop = 1;
            end else begin
                nr = clamp(((zr * zr - zi * zi) >>> FRAC) + cr);
                ni = clamp(((2 * zr * zi) >>> FRAC) + ci);
`ifdef MANDEL_PERIOD_EN
                if (sv && nr == sr && ni == si) begin
                    esc = 0; cnt = mx; stop = 1;
                end else if (((n + 1) & n) == 0) begin
                    sr = nr; si = ni; sv = 1;
                end
`endif
                zr = nr;
                zi = ni;
            end
        end
        if (!esc) col = 0;
        else case (mode)
            0: col = (cnt % 4) * 21;
            1: col = (cnt % 4) * 16 + ((cnt / 4) % 4) * 4 + (cnt / 16) % 4;
            2: col = 63;
            default: col = (cnt % 2) ? 48 : 3;
        endcase
    endfunction

    task automatic run_point(input logic [WIDTH-1:0] cr, input logic [WIDTH-1:0] ci, input int mx,
                             input int mode, input int stall_at, input bit hold);
        int cnt, col, cyc, k, lat, exp_lat;
        bit esc;
        logic [ITER_W-1:0] h_cnt;
        logic [5:0] h_col;
        logic h_esc;
        model($signed(cr), $signed(ci), mx, mode, cnt, esc, col, cyc);
        exp_lat = (stall_at >= 0 && stall_at < cyc) ? cyc + 3 : cyc;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.c_re        = cr;
        bus.c_im        = ci;
        bus.max_iter    = ITER_W'(mx);
        bus.colour_mode = 2'(mode);
        bus.out_ready   = !hold;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_idle", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("busy_iter", bus.busy, 1);
        lat = 0;
        while (!bus.out_valid && lat < 1000) begin
            if (lat == stall_at) begin
                en = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1 lat++;
                end
                en = 1'b1;
            end else begin
                @(posedge clk);
                #1 lat++;
            end
        end
        chk("out_valid", bus.out_valid, 1);
        chk("latency", lat, exp_lat);
        chk("iter_count", bus.iter_count, cnt);
        chk("escaped", bus.escaped, esc);
        chk("colour", bus.colour, col);
        if (hold) begin
            h_cnt = bus.iter_count;
            h_col = bus.colour;
            h_esc = bus.escaped;
            repeat (5) @(posedge clk);
            #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_count", bus.iter_count, h_cnt);
            chk("hold_colour", bus.colour, h_col);
            chk("hold_escaped", bus.escaped, h_esc);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("drop_valid", bus.out_valid, 0);
        chk("back_idle", bus.in_ready, 1);
    endtask

    initial begin
        bit seen;
        bus.in_valid    = 1'b0;
        bus.c_re        = '0;
        bus.c_im        = '0;
        bus.max_iter    = '0;
        bus.colour_mode = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_iter_count", bus.iter_count, 0);
        chk("rst_colour", bus.colour, 0);
        rst_n = 1'b1;
        #10;
        chk("rst_in_ready", bus.in_ready, 1);

        run_point(16'h1000, 16'h0000, 20, 0, -1, 0);
        run_point(16'h0000, 16'h0000, 20, 0, -1, 0);
        run_point(16'hE000, 16'h0000, 20, 0, -1, 0);
        run_point(16'h2000, 16'h0000, 1, 0, -1, 0);
        for (int m = 0; m < 4; m++) run_point(16'h2000, 16'h0000, 2, m, -1, 0);
        run_point(16'h1000, 16'h0000, 0, 1, -1, 0);
        run_point(16'h7E66, 16'h0000, 10, 3, -1, 1);
        run_point(16'h8000, 16'h8000, 10, 2, -1, 0);
        run_point(16'h0000, 16'h0000, 20, 0, 2, 0);
        run_point(16'hF000, 16'h0000, 30, 1, 4, 0);

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] r, im;
            if (i % 4 == 0) begin
                r  = WIDTH'($urandom);
                im = WIDTH'($urandom);
            end else begin
                r  = WIDTH'($urandom_range(0, 14000)) - WIDTH'(10000);
                im = WIDTH'($urandom_range(0, 10000)) - WIDTH'(5000);
            end
            run_point(r, im, int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), -1, $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.c_re     = '0;
        bus.c_im     = '0;
        bus.max_iter = ITER_W'(20);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen = 1;
        end
        chk("rst_mid_no_valid", seen, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_count", bus.iter_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
